mod_add_select_stage2: RTL
==========================

Name: mod_add_select_stage2

Overview:
- Stage 2 of the two-stage modular adder, directly downstream of the stage-1 dual-sum circuit.
- Stage 1 delivers the raw sum A+B, the pre-reduced sum A+B-MODULUS, and the sign of the pre-reduced sum.
- This block selects the reduced residue, range-checks it against MODULUS for fault detection, and presents it through a valid/ready output with a 2-entry skid buffer, so downstream backpressure never drops a result.

Parameters:
- DATA_WIDTH, 18: residue width; matches stage-1 result width.
- MODULUS, 177147: modulus; a selected value >= MODULUS is a range fault.
- CNT_WIDTH, 16: width of the saturating fault counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  stage-1 outputs valid this cycle; the producer aligns it to stage-1's 1-cycle latency.
- in_ready  out  1  block can accept in_valid this cycle.
- sum_raw  in  DATA_WIDTH  stage-1 A+B (result_A).
- sum_sub  in  DATA_WIDTH  stage-1 low bits of A+B-MODULUS (result_B).
- sign_in  in  1  sign of A+B-MODULUS; 1 = negative.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  DATA_WIDTH  reduced residue.
- out_err  out  1  range fault flag travelling with out_data.
- err_clr  in  1  clears err_count.
- err_count  out  CNT_WIDTH  saturating count of accepted range faults.

Behaviour:
- Selection: sel = sign_in ? sum_raw : sum_sub.
- Range check: fault = (sel >= MODULUS), computed on the full DATA_WIDTH unsigned value. A fault-free stage 1 never produces one.
- Faulted data still passes through unchanged with out_err=1; the data is not corrected here.
- Accept event: in_valid && in_ready. An input presented while in_ready=0 is ignored; the producer holds it.
- Storage: main register M (drives out_data/out_err/out_valid) and skid register S, each holding {data, err, valid}.
- Latency: accepted input appears on out_data the next cycle when M is empty or draining (out_ready=1). Throughput is 1/cycle with no stall.
- Accept while M is empty, or M is valid and out_ready=1 with S empty: the input loads into M.
- Accept while M is valid, out_ready=0, and S is empty: the input loads into S.
- M drains (out_ready=1) while S is valid: S moves into M and S empties. A simultaneous accept is impossible, because in_ready=0 while S is valid.
- in_ready is a registered output, equal to !S.valid after the update. It never depends combinationally on out_ready.
- out_data/out_err hold stable while out_valid=1 and out_ready=0.
- Counter: on each accept with fault=1, err_count increments; it saturates at 2^CNT_WIDTH-1.
- err_clr has priority: err_count goes to 0 that cycle and a same-cycle fault is not counted.
- Reset (rst_n=0 at a clk edge): M and S are invalidated, out_valid=0, out_data=0, out_err=0, err_count=0, in_ready=1.
- A reset mid-stream discards buffered results. Inputs presented during reset are not accepted.
- Boundaries:
  - sel == MODULUS-1 is valid (no fault).
  - sel == MODULUS is a fault.
  - sum_sub with sign_in=0 is used as-is (no further reduction).

Test Plan:
- Normal reduce: DATA_WIDTH=18, MODULUS=177147. In1: sum_raw=150000, sign_in=1 (A=100000, B=50000). In2: sum_sub=32853, sign_in=0 (A=150000, B=60000). Inputs on consecutive cycles with out_ready=1 -> out_data=150000 then 32853 on the following cycles, out_err=0, no bubbles.
- Boundary: sum_raw=177146, sign_in=1 -> out_data=177146, out_err=0. Then sum_raw=177147, sign_in=1 -> out_err=1, err_count=1.
- Backpressure: hold out_ready=0 and offer 3 inputs (10, 20, 30) -> 10 sits in M, 20 in S, in_ready=0 from the cycle after 20 is accepted, 30 held by the producer. Release out_ready -> 10, 20, 30 out in order, none lost or duplicated.
- Fault counting: inject 5 faults (sign_in=1, sum_raw=200000), then assert err_clr together with a 6th fault -> err_count=5, then 0. With CNT_WIDTH=2 -> err_count saturates at 3.
- Reset mid-operation: with M and S full, pulse rst_n=0 for one cycle -> next cycle out_valid=0, out_data=0, in_ready=1, err_count=0; the first post-reset input emerges after 1 cycle.
- Random streams: random stage-1 operands A<2^18, B<2^16 with random out_ready -> out_data equals (A+B) mod 177147 in order, with out_err always 0.

Source files
------------

// File: rtl/mod_add_select_stage2.sv
// Stage 2 of the two-stage modular adder.
// Picks the reduced residue from the stage-1 dual sums, flags values that
// fall outside [0, MODULUS) and hands the result out through a valid/ready
// port backed by a 2-entry skid buffer (main register M, skid register S).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer keeps its data stable until that transfer happens.
// in_ready comes straight from a flop (it is high while S is empty) and
// never depends combinationally on out_ready.
module mod_add_select_stage2 #(
  parameter int DATA_WIDTH = 18,
  parameter int MODULUS    = 177147,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] sum_raw,
  input  logic [DATA_WIDTH-1:0] sum_sub,
  input  logic                  sign_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // One extra bit keeps the compare correct even if MODULUS == 2^DATA_WIDTH.
  localparam logic [DATA_WIDTH:0]  LP_MOD     = (DATA_WIDTH + 1)'(MODULUS);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] w_sel;
  logic                  w_fault;
  logic                  w_accept;
  logic                  w_drain;

  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_err;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_s_data;
  logic                  r_s_err;
  logic                  r_s_valid;
  logic                  r_in_ready;
  logic [CNT_WIDTH-1:0]  r_err_count;

  logic [DATA_WIDTH-1:0] w_m_data_nxt;
  logic                  w_m_err_nxt;
  logic                  w_m_valid_nxt;
  logic [DATA_WIDTH-1:0] w_s_data_nxt;
  logic                  w_s_err_nxt;
  logic                  w_s_valid_nxt;
  logic                  w_in_ready_nxt;
  logic [CNT_WIDTH-1:0]  w_err_count_nxt;

  // Select the reduced residue and range-check it; classify handshake events.
  always_comb begin
    w_sel    = sign_in ? sum_raw : sum_sub;
    w_fault  = ({1'b0, w_sel} >= LP_MOD);
    w_accept = in_valid && r_in_ready;
    w_drain  = r_m_valid && out_ready;
  end

  // Skid buffer update: new data goes to M unless M is stalled, then to S.
  // An accept cannot coincide with S being full since in_ready is low then.
  always_comb begin
    w_m_data_nxt  = r_m_data;
    w_m_err_nxt   = r_m_err;
    w_m_valid_nxt = r_m_valid;
    w_s_data_nxt  = r_s_data;
    w_s_err_nxt   = r_s_err;
    w_s_valid_nxt = r_s_valid;
    if (w_accept) begin
      if (!r_m_valid || out_ready) begin
        w_m_data_nxt  = w_sel;
        w_m_err_nxt   = w_fault;
        w_m_valid_nxt = 1'b1;
      end else begin
        w_s_data_nxt  = w_sel;
        w_s_err_nxt   = w_fault;
        w_s_valid_nxt = 1'b1;
      end
    end else if (w_drain) begin
      if (r_s_valid) begin
        w_m_data_nxt  = r_s_data;
        w_m_err_nxt   = r_s_err;
        w_m_valid_nxt = 1'b1;
        w_s_valid_nxt = 1'b0;
      end else begin
        w_m_valid_nxt = 1'b0;
      end
    end
    w_in_ready_nxt = !w_s_valid_nxt;
  end

  // Saturating fault counter; a clear wins over a same-cycle fault.
  always_comb begin
    w_err_count_nxt = r_err_count;
    if (err_clr) begin
      w_err_count_nxt = '0;
    end else if (w_accept && w_fault && (r_err_count != LP_CNT_MAX)) begin
      w_err_count_nxt = r_err_count + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_data    <= '0;
      r_m_err     <= 1'b0;
      r_m_valid   <= 1'b0;
      r_s_data    <= '0;
      r_s_err     <= 1'b0;
      r_s_valid   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_err_count <= '0;
    end else begin
      r_m_data    <= w_m_data_nxt;
      r_m_err     <= w_m_err_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_s_data    <= w_s_data_nxt;
      r_s_err     <= w_s_err_nxt;
      r_s_valid   <= w_s_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign out_err   = r_m_err;
  assign err_count = r_err_count;

endmodule
